ieeedrv_host: RTL and testbench

// - Host-side (controller/talker/listener) IEEE-488 engine. It is the initiator

---
 rtl/ieeedrv_host.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_ieeedrv_host.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ieeedrv_host.sv
// ============================================================================
// Module   : ieeedrv_host
// Purpose  : Host-side IEEE-488 engine (controller / talker / listener).
//            Runs the 3-wire DAV/NRFD/NDAC handshake on the shared bus from
//            byte-level commands and returns received bytes and status.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ieeedrv_pkg;
  // One bit per bus line; 1 = line asserted (electrically low).
  typedef struct packed {
    logic [7:0] data;
    logic       atn;
    logic       dav;
    logic       nrfd;
    logic       ndac;
    logic       eoi;
    logic       ifc;
    logic       srq;
    logic       ren;
  } st_ieee_bus;
endpackage

module ieeedrv_host
  import ieeedrv_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = 16'd64000,
  parameter logic [3:0]  SETTLE  = 4'd2
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce,
  input  st_ieee_bus bus_i,
  output st_ieee_bus bus_o,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  input  logic       cmd_eoi,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_eoi,
  output logic [1:0] rsp_err
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_SETUP   = 4'd1;
  localparam logic [3:0] S_CHECK   = 4'd2;
  localparam logic [3:0] S_WAITRFD = 4'd3;
  localparam logic [3:0] S_WAITDAC = 4'd4;
  localparam logic [3:0] S_RXRDY   = 4'd5;
  localparam logic [3:0] S_RXDAV   = 4'd6;
  localparam logic [3:0] S_RXNDAV  = 4'd7;
  localparam logic [3:0] S_TURN    = 4'd8;
  localparam logic [3:0] S_DONE    = 4'd9;

  localparam logic [1:0] OP_ATN  = 2'd0;
  localparam logic [1:0] OP_DATA = 2'd1;
  localparam logic [1:0] OP_RX   = 2'd2;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_NODEV = 2'd1;
  localparam logic [1:0] ERR_TMO   = 2'd2;

  // Talker-turnaround length in ce ticks.
  localparam logic [3:0] C_TURN_TICKS = 4'd2;

  logic [3:0]  state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic        atn_q, atn_d, dav_q, dav_d, nrfd_q, nrfd_d, ndac_q, ndac_d, eoi_q, eoi_d;
  logic [7:0]  data_q, data_d;
  logic        ready_q, ready_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        rsp_eoi_q, rsp_eoi_d;
  logic [1:0]  err_q, err_d;

  logic [15:0] w_timer_inc;
  logic        w_expired;
  logic [3:0]  w_cnt_inc;
  logic        w_wait_state;
  logic        w_tmo_fire;
  logic        w_unused_bits;

  // Timer saturates at the compare value so it can never wrap.
  assign w_timer_inc  = (timer_q == TIMEOUT) ? timer_q : timer_q + 16'd1;
  assign w_expired    = (timer_q == TIMEOUT) || (w_timer_inc == TIMEOUT);
  assign w_cnt_inc    = cnt_q + 4'd1;
  assign w_wait_state = (state_q == S_WAITRFD) || (state_q == S_WAITDAC) ||
                        (state_q == S_RXDAV)   || (state_q == S_RXNDAV);
  // SRQ/REN are not serviced and our own ATN is never read back from the bus.
  assign w_unused_bits = ^{bus_i.atn, bus_i.srq, bus_i.ren};

  // Next-state logic: handshake sequencing, ce-gated except DONE -> IDLE.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    atn_d      = atn_q;
    dav_d      = dav_q;
    nrfd_d     = nrfd_q;
    ndac_d     = ndac_q;
    eoi_d      = eoi_q;
    data_d     = data_q;
    ready_d    = ready_q;
    rsp_data_d = rsp_data_q;
    rsp_eoi_d  = rsp_eoi_q;
    err_d      = err_q;
    w_tmo_fire = 1'b0;

    if (state_q == S_DONE) begin
      // DONE lasts one clk_sys cycle so rsp_valid is a single-cycle pulse.
      state_d = S_IDLE;
      ready_d = 1'b1;
    end else if (ce) begin
      if (bus_i.ifc && (state_q != S_IDLE)) begin
        atn_d   = 1'b0;
        dav_d   = 1'b0;
        nrfd_d  = 1'b0;
        ndac_d  = 1'b0;
        eoi_d   = 1'b0;
        data_d  = 8'h00;
        err_d   = ERR_TMO;
        state_d = S_DONE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (!ready_q) begin
              ready_d = 1'b1;
            end else if (cmd_valid) begin
              ready_d = 1'b0;
              op_d    = cmd_op;
              cnt_d   = 4'd0;
              if (cmd_op == OP_RX) begin
                state_d = S_RXRDY;
              end else if (cmd_op[1]) begin
                atn_d   = 1'b0;
                ndac_d  = 1'b1;
                state_d = S_TURN;
              end else begin
                atn_d   = (cmd_op == OP_ATN) ? 1'b1 : atn_q;
                eoi_d   = (cmd_op == OP_DATA) ? cmd_eoi : 1'b0;
                data_d  = cmd_data;
                nrfd_d  = 1'b0;
                ndac_d  = 1'b0;
                state_d = S_SETUP;
              end
            end
          end
          S_SETUP: begin
            cnt_d = w_cnt_inc;
            if (w_cnt_inc >= SETTLE) state_d = S_CHECK;
          end
          S_CHECK: begin
            if (!bus_i.nrfd && !bus_i.ndac) begin
              data_d  = 8'h00;
              eoi_d   = 1'b0;
              err_d   = ERR_NODEV;
              state_d = S_DONE;
            end else begin
              state_d = S_WAITRFD;
            end
          end
          S_WAITRFD: begin
            if (!bus_i.nrfd) begin
              dav_d   = 1'b1;
              state_d = S_WAITDAC;
            end else if (w_expired) begin
              w_tmo_fire = 1'b1;
            end
          end
          S_WAITDAC: begin
            if (!bus_i.ndac) begin
              dav_d   = 1'b0;
              data_d  = 8'h00;
              eoi_d   = 1'b0;
              err_d   = ERR_OK;
              state_d = S_DONE;
            end else if (w_expired) begin
              w_tmo_fire = 1'b1;
            end
          end
          S_RXRDY: begin
            ndac_d  = 1'b1;
            nrfd_d  = 1'b0;
            state_d = S_RXDAV;
          end
          S_RXDAV: begin
            if (bus_i.dav) begin
              rsp_data_d = bus_i.data;
              rsp_eoi_d  = bus_i.eoi;
              nrfd_d     = 1'b1;
              ndac_d     = 1'b0;
              state_d    = S_RXNDAV;
            end else if (w_expired) begin
              w_tmo_fire = 1'b1;
            end
          end
          S_RXNDAV: begin
            if (!bus_i.dav) begin
              ndac_d  = 1'b1;
              err_d   = ERR_OK;
              state_d = S_DONE;
            end else if (w_expired) begin
              w_tmo_fire = 1'b1;
            end
          end
          S_TURN: begin
            cnt_d = w_cnt_inc;
            if (w_cnt_inc >= C_TURN_TICKS) begin
              err_d   = ERR_OK;
              state_d = S_DONE;
            end
          end
          default: state_d = S_IDLE;
        endcase

        // Timeout keeps NDAC so a stalled talker stays held off.
        if (w_tmo_fire) begin
          dav_d   = 1'b0;
          data_d  = 8'h00;
          eoi_d   = 1'b0;
          nrfd_d  = 1'b0;
          if (op_q == OP_ATN) atn_d = 1'b0;
          err_d   = ERR_TMO;
          state_d = S_DONE;
        end
      end
    end

    if (state_d != state_q) begin
      timer_d = 16'd0;
    end else if (ce && w_wait_state) begin
      timer_d = w_timer_inc;
    end
  end

  // State and bus-drive registers; reset releases every line at once.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= S_IDLE;
      timer_q    <= 16'd0;
      cnt_q      <= 4'd0;
      op_q       <= 2'd0;
      atn_q      <= 1'b0;
      dav_q      <= 1'b0;
      nrfd_q     <= 1'b0;
      ndac_q     <= 1'b0;
      eoi_q      <= 1'b0;
      data_q     <= 8'h00;
      ready_q    <= 1'b0;
      rsp_data_q <= 8'h00;
      rsp_eoi_q  <= 1'b0;
      err_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      atn_q      <= atn_d;
      dav_q      <= dav_d;
      nrfd_q     <= nrfd_d;
      ndac_q     <= ndac_d;
      eoi_q      <= eoi_d;
      data_q     <= data_d;
      ready_q    <= ready_d;
      rsp_data_q <= rsp_data_d;
      rsp_eoi_q  <= rsp_eoi_d;
      err_q      <= err_d;
    end
  end

  // Bus drive assembly; SRQ, REN and IFC are never driven by this node.
  always_comb begin
    bus_o      = '0;
    bus_o.data = data_q;
    bus_o.atn  = atn_q;
    bus_o.dav  = dav_q;
    bus_o.nrfd = nrfd_q;
    bus_o.ndac = ndac_q;
    bus_o.eoi  = eoi_q;
  end

  assign cmd_ready = ready_q;
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_data  = rsp_data_q;
  assign rsp_eoi   = rsp_eoi_q;
  assign rsp_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_ieeedrv_host.sv
// ============================================================================
// Module   : tb_ieeedrv_host
// Purpose  : Directed self-checking bench for ieeedrv_host with simple
//            listener / talker device models on an OR-resolved bus.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ieeedrv_host;
  import ieeedrv_pkg::*;

  localparam logic [15:0] TB_TIMEOUT = 16'd40;

  logic       clk_sys, reset, ce;
  st_ieee_bus bus_i, bus_o;
  st_ieee_bus dev_scr, dev_lst, dev_tlk;
  logic       cmd_valid, cmd_ready, cmd_eoi;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid, rsp_eoi;
  logic [7:0] rsp_data;
  logic [1:0] rsp_err;

  int checks = 0, failures = 0;
  int tick_cnt = 0;
  int acc_tick, rsp_tick, dav_tick, dav_rises = 0;
  logic [7:0] dav_data;
  logic       dav_eoi, dav_atn, dav_prev = 1'b0;
  logic [7:0] r_data;
  logic       r_eoi;
  logic [1:0] r_err;
  st_ieee_bus r_bus;
  logic       lst_en = 1'b0, tlk_en = 1'b0;
  logic [7:0] tx_data [0:2];
  logic       tx_eoi  [0:2];
  int         tx_idx = 0;

  ieeedrv_host #(.TIMEOUT(TB_TIMEOUT), .SETTLE(4'd2)) dut (
    .clk_sys(clk_sys), .reset(reset), .ce(ce),
    .bus_i(bus_i), .bus_o(bus_o),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_eoi(cmd_eoi),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_eoi(rsp_eoi), .rsp_err(rsp_err)
  );

  // Wired-OR of every node on the bus.
  always_comb bus_i = st_ieee_bus'(bus_o | dev_scr | dev_lst | dev_tlk);

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // ce is high every other clk_sys cycle, changing well away from the edge.
  initial begin
    ce = 1'b0;
    forever begin
      @(posedge clk_sys);
      #2 ce = ~ce;
    end
  end

  always @(posedge clk_sys) if (ce) tick_cnt <= tick_cnt + 1;

  // Record each rising DAV and what was on the bus with it.
  initial forever begin
    @(negedge clk_sys);
    if (bus_o.dav && !dav_prev) begin
      dav_rises = dav_rises + 1;
      dav_tick  = tick_cnt;
      dav_data  = bus_o.data;
      dav_eoi   = bus_o.eoi;
      dav_atn   = bus_o.atn;
    end
    dav_prev = bus_o.dav;
  end

  // Cooperative listener: always ready, accepts while DAV is asserted.
  initial begin
    dev_lst = '0;
    forever begin
      @(negedge clk_sys);
      if (lst_en) begin
        dev_lst.nrfd = 1'b0;
        dev_lst.ndac = !bus_o.dav;
      end else begin
        dev_lst = '0;
      end
    end
  end

  // Talker: sends the tx table in order when a listener is ready.
  initial begin
    dev_tlk = '0;
    forever begin
      @(negedge clk_sys);
      if (!tlk_en) begin
        dev_tlk = '0;
      end else if (!dev_tlk.dav) begin
        if (tx_idx < 3 && !bus_i.nrfd && bus_i.ndac) begin
          dev_tlk.data = tx_data[tx_idx];
          dev_tlk.eoi  = tx_eoi[tx_idx];
          dev_tlk.dav  = 1'b1;
        end
      end else if (!bus_i.ndac) begin
        dev_tlk = '0;
        tx_idx  = tx_idx + 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tick();
    @(posedge clk_sys);
    while (!ce) @(posedge clk_sys);
    #1;
  endtask

  // Present a command and return just after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [7:0] d, input logic e, input bit hold);
    bit ok;
    ok = 1'b0;
    cmd_op = op; cmd_data = d; cmd_eoi = e; cmd_valid = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk_sys);
      if (cmd_ready && ce) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept", {31'b0, ok}, 32'd1);
    @(posedge clk_sys);
    #1;
    acc_tick = tick_cnt;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk_sys);
      if (rsp_valid) begin
        r_data = rsp_data; r_eoi = rsp_eoi; r_err = rsp_err;
        r_bus = bus_o; rsp_tick = tick_cnt;
        ok = 1'b1;
        break;
      end
    end
    check("rsp_seen", {31'b0, ok}, 32'd1);
  endtask

  initial begin
    int base;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 8'h00; cmd_eoi = 1'b0;
    dev_scr = '0;
    tx_data[0] = 8'h01; tx_eoi[0] = 1'b0;
    tx_data[1] = 8'h04; tx_eoi[1] = 1'b0;
    tx_data[2] = 8'h0D; tx_eoi[2] = 1'b1;
    repeat (4) @(negedge clk_sys);
    check("rst_bus", bus_o, 32'h0);
    check("rst_ready", cmd_ready, 32'd0);
    check("rst_rsp_valid", rsp_valid, 32'd0);
    check("rst_rsp", {rsp_data, rsp_eoi, rsp_err}, 32'h0);
    reset = 1'b0;
    wait_tick();
    check("ready_after_rst", cmd_ready, 32'd1);

    // 1: op 0 with scripted listener (NRFD off after 3 ticks, NDAC after 5).
    dev_scr.nrfd = 1'b1; dev_scr.ndac = 1'b1;
    issue(2'd0, 8'h28, 1'b0, 1'b0);
    repeat (3) wait_tick();
    dev_scr.nrfd = 1'b0;
    repeat (2) wait_tick();
    dev_scr.ndac = 1'b0;
    wait_rsp();
    check("t1_err", r_err, 32'd0);
    check("t1_settle_ticks", dav_tick - acc_tick, 32'd4);
    check("t1_dav_data", dav_data, 32'h28);
    check("t1_dav_atn", dav_atn, 32'd1);
    check("t1_done_dav_data", {r_bus.dav, r_bus.data}, 32'h0);
    check("t1_done_atn", r_bus.atn, 32'd1);
    dev_scr = '0;

    // 2: op 0 with nobody on the bus.
    base = dav_rises;
    issue(2'd0, 8'h3F, 1'b0, 1'b0);
    wait_rsp();
    check("t2_err", r_err, 32'd1);
    check("t2_ticks", rsp_tick - acc_tick, 32'd3);
    check("t2_no_dav", dav_rises - base, 32'd0);

    // 3: TALK 8, SA 0, turnaround, then receive three bytes.
    lst_en = 1'b1;
    issue(2'd0, 8'h48, 1'b0, 1'b0);
    wait_rsp();
    check("t3_talk_err", r_err, 32'd0);
    check("t3_talk_byte", dav_data, 32'h48);
    issue(2'd0, 8'h60, 1'b0, 1'b0);
    wait_rsp();
    check("t3_sa_err", r_err, 32'd0);
    lst_en = 1'b0;
    issue(2'd3, 8'h00, 1'b0, 1'b0);
    wait_rsp();
    check("t3_turn_err", r_err, 32'd0);
    check("t3_turn_atn_ndac", {r_bus.atn, r_bus.ndac}, 32'b01);
    tlk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(2'd2, 8'h00, 1'b0, 1'b0);
      wait_rsp();
      check($sformatf("t3_rx%0d_err", i), r_err, 32'd0);
      check($sformatf("t3_rx%0d_data", i), r_data, {24'h0, tx_data[i]});
      check($sformatf("t3_rx%0d_eoi", i), r_eoi, {31'h0, tx_eoi[i]});
      check($sformatf("t3_rx%0d_hold", i), {r_bus.nrfd, r_bus.ndac}, 32'b11);
    end
    tlk_en = 1'b0;
    check("t3_atn_clear", bus_o.atn, 32'd0);

    // 4a: op 0 timeout also drops ATN.
    dev_scr.nrfd = 1'b0; dev_scr.ndac = 1'b1;
    issue(2'd0, 8'h21, 1'b0, 1'b0);
    wait_rsp();
    check("t4a_err", r_err, 32'd2);
    check("t4a_ticks", rsp_tick - dav_tick, {16'h0, TB_TIMEOUT});
    check("t4a_bus", r_bus, 32'h0);

    // 4: op 1 with EOI, listener holds NDAC forever.
    issue(2'd1, 8'h55, 1'b1, 1'b0);
    wait_rsp();
    check("t4_err", r_err, 32'd2);
    check("t4_ticks", rsp_tick - dav_tick, {16'h0, TB_TIMEOUT});
    check("t4_dav_eoi", dav_eoi, 32'd1);
    check("t4_bus", r_bus, 32'h0);

    // 5: reset while DAV is held in WAIT_DAC.
    issue(2'd0, 8'h77, 1'b0, 1'b0);
    begin
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 100; n++) begin
        @(negedge clk_sys);
        if (bus_o.dav) begin
          seen = 1'b1;
          break;
        end
      end
      check("t5_dav_up", {31'b0, seen}, 32'd1);
    end
    reset = 1'b1;
    @(posedge clk_sys);
    #1;
    check("t5_bus", bus_o, 32'h0);
    check("t5_rsp_valid", rsp_valid, 32'd0);
    check("t5_rsp_data", rsp_data, 32'h0);
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    dev_scr = '0;
    check("t5_ready_low", cmd_ready, 32'd0);
    wait_tick();
    check("t5_ready_first_ce", cmd_ready, 32'd1);

    // 6: back-to-back op 1 with cmd_valid held high.
    lst_en = 1'b1;
    base = dav_rises;
    issue(2'd1, 8'hA1, 1'b0, 1'b1);
    cmd_data = 8'hB2; cmd_eoi = 1'b1;
    wait_rsp();
    check("t6_first_err", r_err, 32'd0);
    check("t6_first_byte", {dav_eoi, dav_data}, 32'h0A1);
    begin
      int r1;
      r1 = rsp_tick;
      issue(2'd1, 8'hB2, 1'b1, 1'b0);
      check("t6_accept_gap", acc_tick - r1, 32'd1);
    end
    wait_rsp();
    check("t6_second_err", r_err, 32'd0);
    check("t6_second_byte", {dav_eoi, dav_data}, 32'h1B2);
    check("t6_dav_rises", dav_rises - base, 32'd2);
    lst_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
